// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner with frame-synchronous input snapshot and active-low outputs.
// Optional leading-zero suppression is enabled by defining SEG7_SCAN_LEADZERO_EN.
module seg7_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 16,
  parameter int GAP    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] GAP_C    = CW'(GAP);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [CW-1:0]          r_cnt;
  logic [IW-1:0]          r_idx;
  logic                   r_armed;
  logic [4*DIGITS-1:0]    r_snap_value;
  logic [DIGITS-1:0]      r_snap_dp;
  logic [DIGITS-1:0]      r_snap_blank;
  logic [6:0]             r_seg_n;
  logic                   r_dp_n;
  logic [DIGITS-1:0]      r_an_n;

  logic                   w_slot_end;
  logic                   w_wrap;
  logic                   w_reload;
  logic [4*DIGITS-1:0]    w_cur_value;
  logic [DIGITS-1:0]      w_cur_dp;
  logic [DIGITS-1:0]      w_cur_blank;
  logic [DIGITS-1:0]      w_sup;
  logic [3:0]             w_nib;
  logic                   w_dig_dp;
  logic                   w_dig_off;
  logic [DIGITS-1:0]      w_an;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_wrap     = w_slot_end && (r_idx == IDX_LAST);
  assign w_reload   = !en || !r_armed || w_wrap;

  // Until the first clock after reset the snapshot is stale, so the live inputs stand in for it.
  assign w_cur_value = r_armed ? r_snap_value : value;
  assign w_cur_dp    = r_armed ? r_snap_dp    : dp;
  assign w_cur_blank = r_armed ? r_snap_blank : blank;

  // Per-digit suppression mask: explicit blanks, plus leading zeros when enabled.
  always_comb begin
    w_sup = w_cur_blank;
`ifdef SEG7_SCAN_LEADZERO_EN
    for (int i = 1; i < DIGITS; i++) begin
      w_sup[i] = w_cur_blank[i] | (((w_cur_value >> (4 * i)) == '0) && !w_cur_dp[i]);
    end
`else
    w_sup = w_cur_blank;
`endif
  end

  // Select the nibble, dot and anode for the current digit index.
  always_comb begin
    w_nib     = 4'h0;
    w_dig_dp  = 1'b0;
    w_dig_off = 1'b1;
    w_an      = '1;
    for (int i = 0; i < DIGITS; i++) begin
      w_nib     = (r_idx == IW'(i)) ? w_cur_value[4*i +: 4] : w_nib;
      w_dig_dp  = (r_idx == IW'(i)) ? w_cur_dp[i]           : w_dig_dp;
      w_dig_off = (r_idx == IW'(i)) ? w_sup[i]              : w_dig_off;
      w_an[i]   = (r_idx != IW'(i));
    end
  end

  // Slot timer and digit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Input snapshot, refreshed only at frame boundaries while scanning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      r_snap_value <= '0;
      r_snap_dp    <= '0;
      r_snap_blank <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_reload) begin
        r_snap_value <= value;
        r_snap_dp    <= dp;
        r_snap_blank <= blank;
      end
    end
  end

  // Registered display outputs; the gap keeps adjacent digits from ghosting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg_n <= 7'h7F;
      r_dp_n  <= 1'b1;
      r_an_n  <= '1;
    end else if (!en || (r_cnt < GAP_C) || w_dig_off) begin
      r_seg_n <= 7'h7F;
      r_dp_n  <= 1'b1;
      r_an_n  <= '1;
    end else begin
      r_seg_n <= ~hex7(w_nib);
      r_dp_n  <= ~w_dig_dp;
      r_an_n  <= w_an;
    end
  end

  assign seg_n = r_seg_n;
  assign dp_n  = r_dp_n;
  assign an_n  = r_an_n;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan (DIGITS=4, DIV=4, GAP=1) against a frame-time reference model.
module tb_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int GAP    = 1;
  localparam int FRAME  = DIGITS * DIV;
  localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_t;
  bit          m_armed;
  logic [15:0] m_value;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .en(en), .value(value), .dp(dp), .blank(blank),
    .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void model_reset();
    m_t     = 0;
    m_armed = 1'b0;
    m_value = 16'h0;
    m_dp    = 4'h0;
    m_blank = 4'h0;
  endfunction

  // Predict the output after the next edge, advance one clock, update the model, settle.
  task automatic step();
    int slot, pos;
    logic [15:0] v;
    logic [3:0] d, b;
    bit dark;
    v = m_armed ? m_value : value;
    d = m_armed ? m_dp    : dp;
    b = m_armed ? m_blank : blank;
    slot = m_t / DIV;
    pos  = m_t % DIV;
    dark = !en || (pos < GAP) || b[slot];
`ifdef SEG7_SCAN_LEADZERO_EN
    if (slot > 0 && ((v >> (4 * slot)) == 16'h0) && !d[slot]) dark = 1'b1;
`endif
    if (dark) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      exp_an = ~(4'b0001 << slot); exp_seg = ~HEX7[v[4*slot +: 4]]; exp_dp = ~d[slot];
    end
    @(posedge clk);
    if (!en) begin
      m_t = 0; m_value = value; m_dp = dp; m_blank = blank;
    end else begin
      if (!m_armed) begin m_value = value; m_dp = dp; m_blank = blank; end
      m_t = (m_t + 1) % FRAME;
      if (m_t == 0) begin m_value = value; m_dp = dp; m_blank = blank; end
    end
    m_armed = 1'b1;
    #1;
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (an_n === target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; value = 16'h1234; dp = 4'h0; blank = 4'h0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if ({an_n, seg_n, dp_n} !== 12'hFFF)
        begin n_fail++; $display("FAIL reset_dark: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1", an_n, seg_n, dp_n); end
    end
    reset = 1'b1;
    model_reset();
    step();
    n_checks++;
    if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
      begin n_fail++; $display("FAIL reset_first_cycle: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
    step();
    n_checks++;
    if (an_n !== 4'hE || seg_n !== 7'h19)
      begin n_fail++; $display("FAIL reset_first_lit: got an=%h seg=%h, expected an=e seg=19", an_n, seg_n); end
  endtask

  task automatic test_scan();
    int lit;
    logic [6:0] want;
    lit = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
        begin n_fail++; $display("FAIL scan_model cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", i, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
      case (an_n)
        4'hE: want = 7'h19;
        4'hD: want = 7'h30;
        4'hB: want = 7'h24;
        4'h7: want = 7'h79;
        default: want = 7'h7F;
      endcase
      n_checks++;
      if (seg_n !== want)
        begin n_fail++; $display("FAIL scan_digit cyc %0d: an=%h got seg=%h, expected seg=%h", i, an_n, seg_n, want); end
      if (an_n !== 4'hF) lit++;
    end
    n_checks++;
    if (lit != 24)
      begin n_fail++; $display("FAIL scan_lit_count: got %0d lit cycles, expected 24", lit); end
  endtask

  task automatic test_midscan();
    logic [3:0] ans  [6] = '{4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] segs [6] = '{7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};
    bit ok;
    wait_an(4'hD, 2 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midscan_sync: digit 1 never lit, expected an=d"); end
    value = 16'hABCD;
    for (int k = 0; k < 6; k++) begin
      wait_an(ans[k], 2 * FRAME, ok);
      n_checks++;
      if (!ok || seg_n !== segs[k])
        begin n_fail++; $display("FAIL midscan_%0d: an=%h found=%0d got seg=%h, expected seg=%h", k, ans[k], ok, seg_n, segs[k]); end
    end
  endtask

  task automatic test_blank_dp();
    blank = 4'b0010; dp = 4'b0001; value = 16'($urandom);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
        begin n_fail++; $display("FAIL blank_model cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", i, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
      if (i >= FRAME + 1) begin
        n_checks++;
        if (an_n === 4'hD || dp_n !== (an_n === 4'hE ? 1'b0 : 1'b1))
          begin n_fail++; $display("FAIL blank_dp cyc %0d: got an=%h dp=%b, expected digit 1 dark and dot only on digit 0", i, an_n, dp_n); end
      end
    end
    blank = 4'h0; dp = 4'h0;
  endtask

  task automatic test_reset_midscan();
    bit ok;
    value = 16'h1234;
    wait_an(4'hB, 3 * FRAME, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_sync: digit 2 never lit, expected an=b"); end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({an_n, seg_n, dp_n} !== 12'hFFF)
      begin n_fail++; $display("FAIL rstmid_async: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1", an_n, seg_n, dp_n); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    n_checks++;
    if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
      begin n_fail++; $display("FAIL rstmid_gap: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
    step();
    n_checks++;
    if (an_n !== 4'hE || seg_n !== 7'h19)
      begin n_fail++; $display("FAIL rstmid_restart: got an=%h seg=%h, expected an=e seg=19", an_n, seg_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
      step();
      n_checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
        begin n_fail++; $display("FAIL random_model cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", i, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
      n_checks++;
      if ($countones(~an_n) > 1)
        begin n_fail++; $display("FAIL random_onehot cyc %0d: got an=%h, expected at most one anode low", i, an_n); end
    end
  endtask

  task automatic test_leadzero();
    logic [6:0] want;
    en = 1'b1; dp = 4'h0; blank = 4'h0; value = 16'h0042;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
        begin n_fail++; $display("FAIL lz_model cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", i, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
      if (i >= FRAME + 1) begin
        case (an_n)
          4'hE: want = 7'h24;
          4'hD: want = 7'h19;
`ifdef SEG7_SCAN_LEADZERO_EN
          4'hB, 4'h7: want = 7'h00;
`else
          4'hB, 4'h7: want = 7'h40;
`endif
          default: want = 7'h7F;
        endcase
        n_checks++;
        if (seg_n !== want)
          begin n_fail++; $display("FAIL lz_0042 cyc %0d: an=%h got seg=%h, expected seg=%h", i, an_n, seg_n, want); end
      end
    end
    value = 16'h0000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      n_checks++;
      if ({an_n, seg_n, dp_n} !== {exp_an, exp_seg, exp_dp})
        begin n_fail++; $display("FAIL lz0_model cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b", i, an_n, seg_n, dp_n, exp_an, exp_seg, exp_dp); end
      if (i >= FRAME + 1) begin
        n_checks++;
`ifdef SEG7_SCAN_LEADZERO_EN
        if (an_n !== 4'hF && !(an_n === 4'hE && seg_n === 7'h40))
          begin n_fail++; $display("FAIL lz_zero cyc %0d: got an=%h seg=%h, expected only an=e with seg=40", i, an_n, seg_n); end
`else
        if (an_n !== 4'hF && seg_n !== 7'h40)
          begin n_fail++; $display("FAIL lz_zero cyc %0d: got an=%h seg=%h, expected seg=40 on lit digits", i, an_n, seg_n); end
`endif
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; value = 16'h0; dp = 4'h0; blank = 4'h0;
    model_reset();
    test_reset();
    test_scan();
    test_midscan();
    test_blank_dp();
    test_reset_midscan();
    test_random();
    test_leadzero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
